thermostat_setpoint: RTL

Parametrised thermostat set-point block: holds a user-adjustable set temperature driven by up/down push-buttons (synchronised, debounced, optional auto-repeat), derives heat/cool demand with hysteresis against the measured temperature from the I2C master, and registers one of four selectable values for the seven-segment display. It sits between the board buttons/switches, the I2C temperature reader and the display driver, and its `display_reg` replaces `c_data` as the display source in the top module.

---
 rtl/thermostat_setpoint.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/thermostat_setpoint.sv
// thermostat_setpoint
//   Holds a user-adjustable set point driven by up/down push-buttons, derives
//   heat/cool demand with hysteresis against the measured temperature, and
//   registers one of four values for the seven-segment display.
//
//   Build option: define THERMO_AUTO_REPEAT_EN to enable auto-repeat while a
//   button is held. Without it each debounced press gives exactly one step.
//
//   Button index convention inside this file: bit 0 = up, bit 1 = down.

module thermostat_setpoint #(
    parameter int WIDTH           = 8,
    parameter int SET_MIN         = 50,
    parameter int SET_MAX         = 90,
    parameter int SET_RESET       = 70,
    parameter int HYST            = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [1:0]       selectionSW,
    input  logic [WIDTH-1:0] c_data,
    output logic [WIDTH-1:0] display_reg,
    output logic [WIDTH-1:0] set_temp,
    output logic             heat_on,
    output logic             cool_on
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] SET_MIN_V   = WIDTH'(SET_MIN);
    localparam logic [WIDTH-1:0] SET_MAX_V   = WIDTH'(SET_MAX);
    localparam logic [WIDTH-1:0] SET_RESET_V = WIDTH'(SET_RESET);
    localparam logic [WIDTH:0]   HYST_V      = (WIDTH + 1)'(HYST);

`ifdef THERMO_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_REPEAT
    } step_state_t;
`else
    typedef enum logic {
        ST_IDLE,
        ST_PRESSED
    } step_state_t;

    // Repeat timing has no effect in the single-step build.
    logic unused_repeat_params;
    assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // ------------------------------------------------------------------
    // Button synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [1:0]            btn_raw;
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            level;
    logic [1:0][DB_W-1:0]  db_cnt;

    assign btn_raw = {btn_down, btn_up};

    // Two-flop synchronisers bring the asynchronous buttons into the clock domain.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            level  <= '0;
            db_cnt <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    level[b]  <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Step generation (one FSM per button)
    // ------------------------------------------------------------------
    step_state_t state      [2];
    step_state_t state_next [2];
    logic [1:0]  step;
    logic [1:0]  step_next;
    logic        both_held;

`ifdef THERMO_AUTO_REPEAT_EN
    logic [1:0][RPT_W-1:0] rpt_cnt;
    logic [1:0][RPT_W-1:0] rpt_cnt_next;
`endif

    // With both buttons down the user intent is ambiguous: freeze stepping.
    assign both_held = &level;

    // State register for both step FSMs, their repeat timers and step pulses.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= ST_IDLE;
            end
            step <= '0;
`ifdef THERMO_AUTO_REPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= state_next[b];
            end
            step <= step_next;
`ifdef THERMO_AUTO_REPEAT_EN
            rpt_cnt <= rpt_cnt_next;
`endif
        end
    end

    // Next-state logic: press edge, hold-to-repeat and release for each button.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b] = state[b];
        end
        step_next = '0;
`ifdef THERMO_AUTO_REPEAT_EN
        rpt_cnt_next = rpt_cnt;
`endif
        for (int b = 0; b < 2; b++) begin
            case (state[b])
                ST_IDLE: begin
                    if (level[b]) begin
                        state_next[b] = ST_PRESSED;
                        step_next[b]  = 1'b1;
`ifdef THERMO_AUTO_REPEAT_EN
                        rpt_cnt_next[b] = '0;
`endif
                    end
                end
                ST_PRESSED: begin
                    if (!level[b]) begin
                        state_next[b] = ST_IDLE;
`ifdef THERMO_AUTO_REPEAT_EN
                        rpt_cnt_next[b] = '0;
                    end else if (!both_held) begin
                        if (rpt_cnt[b] == DELAY_LAST) begin
                            state_next[b]   = ST_REPEAT;
                            step_next[b]    = 1'b1;
                            rpt_cnt_next[b] = '0;
                        end else begin
                            rpt_cnt_next[b] = rpt_cnt[b] + 1'b1;
                        end
`endif
                    end
                end
`ifdef THERMO_AUTO_REPEAT_EN
                ST_REPEAT: begin
                    if (!level[b]) begin
                        state_next[b]   = ST_IDLE;
                        rpt_cnt_next[b] = '0;
                    end else if (!both_held) begin
                        if (rpt_cnt[b] == PERIOD_LAST) begin
                            step_next[b]    = 1'b1;
                            rpt_cnt_next[b] = '0;
                        end else begin
                            rpt_cnt_next[b] = rpt_cnt[b] + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_next[b] = ST_IDLE;
                end
            endcase
        end
        step_next = step_next & ~{2{both_held}};
    end

    // ------------------------------------------------------------------
    // Set-point register
    // ------------------------------------------------------------------
    logic step_up;
    logic step_down;

    assign step_up   = step[0] & ~step[1];
    assign step_down = step[1] & ~step[0];

    // Saturating up/down counter; a step at a limit is consumed without effect.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            set_temp <= SET_RESET_V;
        end else if (step_up && (set_temp < SET_MAX_V)) begin
            set_temp <= set_temp + 1'b1;
        end else if (step_down && (set_temp > SET_MIN_V)) begin
            set_temp <= set_temp - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Demand with hysteresis and display selection
    // ------------------------------------------------------------------
    logic [WIDTH:0]   temp_ext;
    logic [WIDTH:0]   set_ext;
    logic             heat_set;
    logic             heat_clr;
    logic             cool_set;
    logic             cool_clr;
    logic             heat_next;
    logic             cool_next;
    logic [WIDTH-1:0] temp_diff;
    logic [WIDTH-1:0] display_next;

    // One extra bit keeps set_temp +/- HYST from wrapping; the "minus" side is
    // rewritten as temp + HYST < set so no subtraction can underflow.
    assign temp_ext = {1'b0, c_data};
    assign set_ext  = {1'b0, set_temp};

    // Hysteresis decision: set outside the band, clear on crossing the set point.
    always_comb begin
        heat_set  = (temp_ext + HYST_V) < set_ext;
        cool_set  = temp_ext > (set_ext + HYST_V);
        heat_clr  = temp_ext >= set_ext;
        cool_clr  = temp_ext <= set_ext;
        heat_next = heat_on;
        cool_next = cool_on;
        if (heat_set && cool_set) begin
            heat_next = 1'b0;
            cool_next = 1'b0;
        end else begin
            if (heat_set) begin
                heat_next = 1'b1;
            end else if (heat_clr) begin
                heat_next = 1'b0;
            end
            if (cool_set) begin
                cool_next = 1'b1;
            end else if (cool_clr) begin
                cool_next = 1'b0;
            end
        end
    end

    // Display source mux: set point, distance from set point, demand flags, or temperature.
    always_comb begin
        temp_diff = (c_data >= set_temp) ? (c_data - set_temp) : (set_temp - c_data);
        case (selectionSW)
            2'b00:   display_next = set_temp;
            2'b01:   display_next = temp_diff;
            2'b10:   display_next = {{(WIDTH - 2){1'b0}}, heat_on, cool_on};
            default: display_next = c_data;
        endcase
    end

    // Output registers for demand flags and display value.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            heat_on     <= 1'b0;
            cool_on     <= 1'b0;
            display_reg <= '0;
        end else begin
            heat_on     <= heat_next;
            cool_on     <= cool_next;
            display_reg <= display_next;
        end
    end

endmodule
